// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x4 matrix keypad model answering a column scanner (press, hold, release, gap).
// Contact bounce and its LFSR are compiled in only when KEYPAD_BOUNCE_EN is defined.
module keypad_emulator #(
    parameter int BOUNCE_CYCLES = 64,
    parameter int HOLD_CYCLES   = 1000,
    parameter int GAP_CYCLES    = 200
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic [3:0] columnas,
    output logic [3:0] filas,
    output logic       busy,
    output logic       pressed
);

    localparam int MAX_BH     = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYCLES = (MAX_BH > GAP_CYCLES) ? MAX_BH : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

`ifdef KEYPAD_BOUNCE_EN
    localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
    typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
`endif

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [3:0]       code_q;
    logic             contact_next;

`ifdef KEYPAD_BOUNCE_EN
    logic [7:0] lfsr;
    logic       in_bounce;

    assign in_bounce = (state == BOUNCE_IN) || (state == BOUNCE_OUT);

    // x^8+x^6+x^5+x^4+1; only advances while the contact is bouncing
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            lfsr <= 8'hA5;
        end else if (in_bounce) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end
`endif

    assign key_ready = (state == IDLE);
    assign busy      = !key_ready;

    // Each state's counter is loaded with its length minus one on entry
    always_comb begin
        state_next   = state;
        cnt_next     = (cnt == '0) ? cnt : cnt - CNT_W'(1);
        contact_next = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (key_valid) begin
`ifdef KEYPAD_BOUNCE_EN
                    state_next = BOUNCE_IN;
                    cnt_next   = BOUNCE_LOAD;
`else
                    state_next = HOLD;
                    cnt_next   = HOLD_LOAD;
`endif
                end
            end
`ifdef KEYPAD_BOUNCE_EN
            BOUNCE_IN: begin
                contact_next = lfsr[0];
                if (cnt == '0) begin
                    state_next = HOLD;
                    cnt_next   = HOLD_LOAD;
                end
            end
`endif
            HOLD: begin
                contact_next = 1'b1;
                if (cnt == '0) begin
`ifdef KEYPAD_BOUNCE_EN
                    state_next = BOUNCE_OUT;
                    cnt_next   = BOUNCE_LOAD;
`else
                    state_next = GAP;
                    cnt_next   = GAP_LOAD;
`endif
                end
            end
`ifdef KEYPAD_BOUNCE_EN
            BOUNCE_OUT: begin
                contact_next = lfsr[0];
                if (cnt == '0) begin
                    state_next = GAP;
                    cnt_next   = GAP_LOAD;
                end
            end
`endif
            GAP: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state   <= IDLE;
            cnt     <= '0;
            code_q  <= 4'h0;
            pressed <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            pressed <= contact_next;
            if (key_valid && key_ready) begin
                code_q <= key_code;
            end
        end
    end

    // Rows are pulled up; the closed key shorts its row to its column only while that column is driven low
    always_comb begin
        filas = 4'b1111;
        if (pressed && !columnas[code_q[1:0]]) begin
            filas[code_q[3:2]] = 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed scoreboard bench for keypad_emulator: press timing, column sweeps, held offers, resets.
module tb_keypad_emulator;

    localparam int B = 8;
    localparam int H = 4;
    localparam int G = 2;
`ifdef KEYPAD_BOUNCE_EN
    localparam bit BOUNCE = 1'b1;
`else
    localparam bit BOUNCE = 1'b0;
`endif
    localparam int BOFF     = BOUNCE ? B : 0;
    localparam int BUSY_CYC = 2 * BOFF + H + G;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [3:0] columnas;
    logic [3:0] filas;
    logic       busy;
    logic       pressed;

    always #5 clk = ~clk;

    keypad_emulator #(
        .BOUNCE_CYCLES(B),
        .HOLD_CYCLES  (H),
        .GAP_CYCLES   (G)
    ) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_ready(key_ready),
        .columnas (columnas),
        .filas    (filas),
        .busy     (busy),
        .pressed  (pressed)
    );

    typedef struct packed {
        logic p;
        logic rdy;
    } exp_t;

    exp_t       sbq[$];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] mlfsr;
    logic [3:0] sweep_pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
`ifdef KEYPAD_BOUNCE_EN
    int         toggles;
`endif

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [3:0] row_model(input logic p, input logic [3:0] code, input logic [3:0] cols);
        logic [3:0] f;
        f = 4'b1111;
        if (p && (cols[code[1:0]] == 1'b0)) f[code[3:2]] = 1'b0;
        return f;
    endfunction

    // Expected contact/ready for every cycle following a transfer edge
    task automatic push_press();
        for (int j = 1; j <= BUSY_CYC + 1; j++) begin
            int   t;
            logic p;
            exp_t e;
            t = j - 1;
            if (t == 0) begin
                p = 1'b0;
            end else if (BOUNCE && ((t <= BOFF) || (t > BOFF + H && t <= 2 * BOFF + H))) begin
                p     = mlfsr[0];
                mlfsr = lfsr_step(mlfsr);
            end else if (t > BOFF && t <= BOFF + H) begin
                p = 1'b1;
            end else begin
                p = 1'b0;
            end
            e.p   = p;
            e.rdy = (j == BUSY_CYC + 1);
            sbq.push_back(e);
        end
    endtask

    task automatic run_press(input logic [3:0] code, input logic [3:0] cols, input bit sweep,
                             input bit keep_valid, input logic [3:0] next_code, input int stop_at);
        int   w;
        int   n;
        exp_t e;
        logic [3:0] cur_cols;
`ifdef KEYPAD_BOUNCE_EN
        logic prev;
        toggles = 0;
        prev    = 1'b0;
`endif
        w = 0;
        while (!key_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", {7'd0, key_ready}, 8'd1);
        if (!key_ready) return;
        columnas  = cols;
        key_valid = 1'b1;
        key_code  = code;
        push_press();
        @(posedge clk);
        n = (stop_at > 0) ? stop_at : BUSY_CYC + 1;
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            if (j == 1) begin
                if (keep_valid) key_code = next_code;
                else key_valid = 1'b0;
            end
            if (sweep) columnas = sweep_pat[j % 4];
            cur_cols = columnas;
            #1;
            e = sbq.pop_front();
            chk("pressed", {7'd0, pressed}, {7'd0, e.p});
            chk("key_ready", {7'd0, key_ready}, {7'd0, e.rdy});
            chk("busy", {7'd0, busy}, {7'd0, !e.rdy});
            chk("filas", {4'd0, filas}, {4'd0, row_model(e.p, code, cur_cols)});
`ifdef KEYPAD_BOUNCE_EN
            if (j >= 2 && j <= B + 1) begin
                if (j > 2 && pressed != prev) toggles++;
                prev = pressed;
            end
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_reset   = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        columnas  = 4'b0000;
        mlfsr     = 8'hA5;
        repeat (3) @(negedge clk);
        chk("rst_filas", {4'd0, filas}, 8'h0F);
        chk("rst_ready", {7'd0, key_ready}, 8'd1);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_pressed", {7'd0, pressed}, 8'd0);
        n_reset = 1'b1;
        @(negedge clk);

        // Row 2 / column 1 with column 1 scanned
        run_press(4'h9, 4'b1101, 1'b0, 1'b0, 4'h0, 0);

        // Same key while the scanner walks its columns
        run_press(4'h9, 4'b1110, 1'b1, 1'b0, 4'h0, 0);

`ifdef KEYPAD_BOUNCE_EN
        run_press(4'h0, 4'b1110, 1'b0, 1'b0, 4'h0, 0);
        chk("bounce_toggles", {7'd0, toggles >= 1}, 8'd1);
`endif

        // Offer held across busy: 4'hF must wait for the first ready edge
        run_press(4'h3, 4'b0000, 1'b0, 1'b1, 4'hF, 0);
        run_press(4'hF, 4'b0000, 1'b0, 1'b0, 4'h0, 0);

        // No column scanned: rows never move
        run_press(4'h6, 4'b1111, 1'b0, 1'b0, 4'h0, 0);

        // Abort mid-hold
        run_press(4'h5, 4'b0000, 1'b0, 1'b0, 4'h0, BOFF + 2);
        chk("hold_before_rst", {4'd0, filas}, 8'h0D);
        n_reset = 1'b0;
        #1;
        chk("midrst_filas", {4'd0, filas}, 8'h0F);
        chk("midrst_ready", {7'd0, key_ready}, 8'd1);
        chk("midrst_busy", {7'd0, busy}, 8'd0);
        chk("midrst_pressed", {7'd0, pressed}, 8'd0);
        sbq.delete();
        mlfsr = 8'hA5;
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);

        run_press(4'hA, 4'b1011, 1'b0, 1'b0, 4'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
